// File: rtl/layer_sched.sv
// layer_sched: multi-layer sequencer sitting above batch_ctrl.
// It holds an NL-entry per-layer configuration table {ss, ds, nb} and steps
// batch_ctrl through up to NL layers per pass. Batch ends are detected on
// batch_ctrl's destination side. Between layers run is dropped so that
// batch_ctrl reinitialises.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset (also clears table)
//   cfg_we/idx/ss/ds/nb table write port (accepted only while idle)
//   nl_m1, start       active layers minus 1 (sampled on start), pass start pulse
//   abort              cancel the pass (keeps table)
//   dst_v/dst_a        batch_ctrl destination word accepted / its address
//   dst_valid          batch_ctrl output register still holds a word
//   run, ss, ds        drive batch_ctrl
//   layer, busy        current layer index, pass in progress
//   done, cfg_err      end-of-pass pulse, rejected-write pulse
module layer_sched #(
   parameter int NL = 4,
   parameter int AW = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [$clog2(NL)-1:0]   cfg_idx,
   input  logic [AW-1:0]           cfg_ss,
   input  logic [AW-1:0]           cfg_ds,
   input  logic [7:0]              cfg_nb,
   input  logic [$clog2(NL)-1:0]   nl_m1,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    dst_v,
   input  logic [AW-1:0]           dst_a,
   input  logic                    dst_valid,
   output logic                    run,
   output logic [AW-1:0]           ss,
   output logic [AW-1:0]           ds,
   output logic [$clog2(NL)-1:0]   layer,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err
);

   localparam int IW = $clog2(NL);

   typedef struct packed {
      logic [AW-1:0] ss;
      logic [AW-1:0] ds;
      logic [7:0]    nb;
   } cfg_t;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_FIN} state_t;

   state_t          state_q, state_d;
   cfg_t            tbl_q [NL];
   cfg_t            tbl_d [NL];
   logic [7:0]      bcnt_q, bcnt_d;
   logic [7:0]      nb_q, nb_d;
   logic [IW-1:0]   nl_q, nl_d;
   logic [IW-1:0]   layer_q, layer_d;
   logic [AW-1:0]   ss_q, ss_d, ds_q, ds_d;
   logic            run_q, run_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            cfg_err_q, cfg_err_d;
   logic            bend;

   // run_q gates bend so that stray dst_v while stopped is ignored
   assign bend = run_q & dst_v & (dst_a == ds_q);

   always_comb begin
      state_d   = state_q;
      tbl_d     = tbl_q;
      bcnt_d    = bcnt_q;
      nb_d      = nb_q;
      nl_d      = nl_q;
      layer_d   = layer_q;
      ss_d      = ss_q;
      ds_d      = ds_q;
      run_d     = run_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;

      if (cfg_we) begin
         if (state_q == S_IDLE) tbl_d[cfg_idx] = '{ss: cfg_ss, ds: cfg_ds, nb: cfg_nb};
         else                   cfg_err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            run_d  = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               state_d = S_LOAD;
               layer_d = '0;
               nl_d    = nl_m1;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            ss_d    = tbl_q[layer_q].ss;
            ds_d    = tbl_q[layer_q].ds;
            nb_d    = tbl_q[layer_q].nb;
            bcnt_d  = '0;
            run_d   = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (bend) begin
               // compare before increment so bcnt never wraps
               if (bcnt_q == nb_q) begin
                  run_d   = 1'b0;
                  state_d = S_GAP;
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end
         end
         S_GAP: begin
            // let the last word leave batch_ctrl's output register first
            if (!dst_valid) begin
               if (layer_q == nl_q) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  layer_d = layer_q + IW'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         run_d   = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         for (int i = 0; i < NL; i++) tbl_q[i] <= '0;
         bcnt_q    <= '0;
         nb_q      <= '0;
         nl_q      <= '0;
         layer_q   <= '0;
         ss_q      <= '0;
         ds_q      <= '0;
         run_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tbl_q     <= tbl_d;
         bcnt_q    <= bcnt_d;
         nb_q      <= nb_d;
         nl_q      <= nl_d;
         layer_q   <= layer_d;
         ss_q      <= ss_d;
         ds_q      <= ds_d;
         run_q     <= run_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign run     = run_q;
   assign ss      = ss_q;
   assign ds      = ds_q;
   assign layer   = layer_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cfg_err = cfg_err_q;

endmodule
